// File: rtl/avalon_interval_timer.sv
// Avalon-MM interval timer: prescaled down-counter with one-shot/periodic reload,
// sticky timeout flag, level interrupt and a registered one-cycle expiry pulse.
module avalon_interval_timer #(
    parameter int DATA_W     = 32,
    parameter int PRESCALE   = 50,
    parameter int PERIOD_RST = 1000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              irq,
    output logic              timeout_pulse
);

    localparam int                PS_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST     = PS_W'(PRESCALE - 1);
    localparam logic [DATA_W-1:0] PERIOD_INIT = DATA_W'(PERIOD_RST);

    logic              run;
    logic              cont;
    logic              ie;
    logic              to_flag;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] counter;
    logic [PS_W-1:0]   prescaler;
    logic [DATA_W-1:0] rd_mux;
    logic              ctrl_wr;
    logic              status_wr;
    logic              period_wr;
    logic              tick;
    logic              expire;

    assign ctrl_wr   = avs_write && (avs_address == 2'd0);
    assign status_wr = avs_write && (avs_address == 2'd1);
    assign period_wr = avs_write && (avs_address == 2'd2);

    // A PERIOD write reloads the counter and swallows any tick of the same cycle.
    assign tick   = run && (prescaler == PS_LAST) && !period_wr;
    assign expire = tick && (counter == '0);
    assign irq    = to_flag & ie;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0:    rd_mux[2:0] = {ie, cont, run};
            2'd1:    rd_mux[1:0] = {run, to_flag};
            2'd2:    rd_mux      = period;
            default: rd_mux      = counter;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            run           <= 1'b0;
            cont          <= 1'b0;
            ie            <= 1'b0;
            to_flag       <= 1'b0;
            period        <= PERIOD_INIT;
            counter       <= PERIOD_INIT;
            prescaler     <= '0;
            avs_readdata  <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            // Starting from stopped restarts the prescale phase; a RUN=1 rewrite keeps it.
            if (period_wr || (ctrl_wr && avs_writedata[0] && !run)) begin
                prescaler <= '0;
            end else if (run) begin
                prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
            end

            if (period_wr) begin
                counter <= avs_writedata;
                period  <= avs_writedata;
            end else if (tick) begin
                counter <= expire ? period : counter - DATA_W'(1);
            end

            // A CTRL write overrides the one-shot auto-stop of the same cycle.
            if (ctrl_wr) begin
                run  <= avs_writedata[0];
                cont <= avs_writedata[1];
                ie   <= avs_writedata[2];
            end else if (expire && !cont) begin
                run <= 1'b0;
            end

            if (expire) begin
                to_flag <= 1'b1;
            end else if (status_wr && avs_writedata[0]) begin
                to_flag <= 1'b0;
            end

            timeout_pulse <= expire;

            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_avalon_interval_timer.sv
// Directed bench for avalon_interval_timer: one instance with PRESCALE=4 (index 0)
// and one with PRESCALE=1 (index 1); register reads go through an expected-value queue.
module tb_avalon_interval_timer;

    logic        clk;
    logic        rst;
    logic [1:0]  address   [2];
    logic        rd_s      [2];
    logic        wr_s      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic        irq_s     [2];
    logic        pulse_s   [2];

    logic [31:0] exp_q[$];
    int          checks;
    int          errors;
    int          early;

    avalon_interval_timer #(.DATA_W(32), .PRESCALE(4), .PERIOD_RST(1000)) u_ps4 (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .avs_address   (address[0]),
        .avs_read      (rd_s[0]),
        .avs_write     (wr_s[0]),
        .avs_writedata (wdata[0]),
        .avs_readdata  (rdata[0]),
        .irq           (irq_s[0]),
        .timeout_pulse (pulse_s[0])
    );

    avalon_interval_timer #(.DATA_W(32), .PRESCALE(1), .PERIOD_RST(1000)) u_ps1 (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .avs_address   (address[1]),
        .avs_read      (rd_s[1]),
        .avs_write     (wr_s[1]),
        .avs_writedata (wdata[1]),
        .avs_readdata  (rdata[1]),
        .irq           (irq_s[1]),
        .timeout_pulse (pulse_s[1])
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct comparison against a bench-computed value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drivers: called at a negedge, the transfer happens on the following posedge.
    task automatic bus_wr(input int s, input logic [1:0] a, input logic [31:0] d);
        address[s] = a;
        wdata[s]   = d;
        wr_s[s]    = 1'b1;
        @(negedge clk);
        wr_s[s]    = 1'b0;
    endtask

    task automatic bus_rd(input int s, input logic [1:0] a, input logic [31:0] exp,
                          input string tag);
        logic [31:0] e;
        address[s] = a;
        rd_s[s]    = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        rd_s[s]    = 1'b0;
        e = exp_q.pop_front();
        checks++;
        assert (rdata[s] === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, rdata[s], e);
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int s = 0; s < 2; s++) begin
            address[s] = 2'd0;
            rd_s[s]    = 1'b0;
            wr_s[s]    = 1'b0;
            wdata[s]   = '0;
        end
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;

        // Reset state
        chk("rst_readdata", rdata[0], 32'd0);
        chk("rst_irq", {31'd0, irq_s[0]}, 32'd0);
        chk("rst_pulse", {31'd0, pulse_s[0]}, 32'd0);
        bus_rd(0, 2'd0, 32'd0, "rst_ctrl");
        bus_rd(0, 2'd1, 32'd0, "rst_status");
        bus_rd(0, 2'd2, 32'd1000, "rst_period");
        bus_rd(0, 2'd3, 32'd1000, "rst_count");

        // One-shot, PRESCALE=4, PERIOD=3: expiry 16 cycles after the CTRL write edge
        bus_wr(0, 2'd2, 32'd3);
        bus_wr(0, 2'd0, 32'h5);
        early = 0;
        for (int n = 1; n < 16; n++) begin
            @(negedge clk);
            early += int'(pulse_s[0]);
        end
        chk("oneshot_early_pulses", early, 0);
        @(negedge clk);
        chk("oneshot_pulse", {31'd0, pulse_s[0]}, 32'd1);
        chk("oneshot_irq", {31'd0, irq_s[0]}, 32'd1);
        bus_rd(0, 2'd1, 32'h1, "oneshot_status");
        bus_rd(0, 2'd3, 32'd3, "oneshot_count");
        bus_rd(0, 2'd0, 32'h4, "oneshot_ctrl");
        early = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            early += int'(pulse_s[0]);
        end
        chk("oneshot_no_repeat", early, 0);

        // Periodic, PRESCALE=1, PERIOD=9: pulse every 10 cycles
        bus_wr(1, 2'd2, 32'd9);
        bus_wr(1, 2'd0, 32'h3);
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            chk($sformatf("periodic_pulse_c%0d", n), {31'd0, pulse_s[1]},
                {31'd0, (n % 10) == 0});
        end
        chk("periodic_irq_masked", {31'd0, irq_s[1]}, 32'd0);

        // Clear racing the expiry at cycle 60: set wins
        wait_cycles(9);
        bus_wr(1, 2'd1, 32'h1);
        chk("race_pulse", {31'd0, pulse_s[1]}, 32'd1);
        bus_rd(1, 2'd1, 32'h3, "race_status");
        bus_wr(1, 2'd0, 32'h7);
        chk("ie_irq_high", {31'd0, irq_s[1]}, 32'd1);
        bus_wr(1, 2'd1, 32'h1);
        chk("clear_irq_low", {31'd0, irq_s[1]}, 32'd0);
        bus_rd(1, 2'd1, 32'h2, "clear_status");
        // RUN rewrite at cycle 62 must not disturb the cycle-70 expiry
        wait_cycles(5);
        chk("rerun_no_pulse", {31'd0, pulse_s[1]}, 32'd0);
        wait_cycles(1);
        chk("rerun_pulse", {31'd0, pulse_s[1]}, 32'd1);
        bus_wr(1, 2'd0, 32'h0);

        // Stop/resume, PRESCALE=4, PERIOD=100: stop at COUNT=60
        bus_wr(0, 2'd2, 32'd100);
        bus_wr(0, 2'd0, 32'h1);
        wait_cycles(160);
        bus_wr(0, 2'd0, 32'h0);
        wait_cycles(50);
        bus_rd(0, 2'd3, 32'd60, "stop_count");
        bus_rd(0, 2'd1, 32'h1, "stop_status");
        bus_wr(0, 2'd0, 32'h1);
        early = 0;
        for (int n = 1; n < 244; n++) begin
            @(negedge clk);
            early += int'(pulse_s[0]);
        end
        chk("resume_early_pulses", early, 0);
        @(negedge clk);
        chk("resume_pulse", {31'd0, pulse_s[0]}, 32'd1);
        bus_rd(0, 2'd3, 32'd100, "resume_count");
        bus_rd(0, 2'd0, 32'h0, "resume_ctrl");

        // Reset on the edge of a periodic expiry
        bus_wr(1, 2'd2, 32'd9);
        bus_wr(1, 2'd0, 32'h7);
        wait_cycles(29);
        chk("prereset_irq", {31'd0, irq_s[1]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_pulse", {31'd0, pulse_s[1]}, 32'd0);
        chk("midreset_irq", {31'd0, irq_s[1]}, 32'd0);
        chk("midreset_readdata", rdata[1], 32'd0);
        bus_rd(1, 2'd0, 32'd0, "midreset_ctrl");
        bus_rd(1, 2'd1, 32'd0, "midreset_status");
        bus_rd(1, 2'd2, 32'd1000, "midreset_period");
        bus_rd(1, 2'd3, 32'd1000, "midreset_count");

        // PERIOD=0 expires on every tick
        bus_wr(1, 2'd2, 32'd0);
        bus_wr(1, 2'd0, 32'h3);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk($sformatf("period0_pulse_c%0d", n), {31'd0, pulse_s[1]}, 32'd1);
        end
        bus_wr(1, 2'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
